// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array edge feeders.
// Counter widths leave headroom so lane offsets (t - i) can be formed without wrap.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feeder_state_t;

  function automatic int feed_cycles(input int dim);
    return 2 * dim - 1;
  endfunction

  function automatic int drain_cycles(input int dim);
    return dim - 1;
  endfunction

  function automatic int cnt_width(input int dim);
    return $clog2(2 * dim) + 1;
  endfunction

  function automatic int idx_width(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

endpackage

// File: rtl/operand_skew_feeder_ctrl.sv
// Feeder sequencer: IDLE -> FEED (2*DIM-1 cycles) -> DRAIN (DIM-1 cycles) -> DONE (1 cycle).
// busy/arr_en/done are registered alongside the state so they switch on the same edge.
module feeder_ctrl
  import systolic_pkg::*;
#(
  parameter int DIM = 32,
  parameter int TW  = cnt_width(DIM)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  output feeder_state_t o_state,
  output logic [TW-1:0] o_t,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_arr_en
);

  localparam int            DRAIN_N    = drain_cycles(DIM);
  localparam logic [TW-1:0] FEED_LAST  = TW'(feed_cycles(DIM) - 1);
  localparam logic [TW-1:0] DRAIN_LAST = TW'((DRAIN_N > 0) ? DRAIN_N - 1 : 0);

  feeder_state_t r_state;
  logic [TW-1:0] r_t;
  logic          r_busy;
  logic          r_done;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_t     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= FEED;
            r_t     <= '0;
            r_busy  <= 1'b1;
          end
        end
        FEED: begin
          if (r_t == FEED_LAST) begin
            r_t <= '0;
            // A 1x1 array has nothing left in flight once the single element is fed.
            if (DRAIN_N == 0) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= DRAIN;
            end
          end else begin
            r_t <= r_t + TW'(1);
          end
        end
        DRAIN: begin
          if (r_t == DRAIN_LAST) begin
            r_state <= DONE;
            r_t     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_t <= r_t + TW'(1);
          end
        end
        DONE: begin
          r_done <= 1'b0;
          r_t    <= '0;
          if (i_start) begin
            r_state <= FEED;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_t     <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_state  = r_state;
  assign o_t      = r_t;
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_arr_en = r_busy;

endmodule

// File: rtl/operand_skew_feeder.sv
// Holds one DIMxDIM operand tile and streams it into an array edge, lane i delayed i cycles.
// Rows are only writable while the sequencer is in IDLE or DONE; writes and starts while busy are dropped.
module operand_skew_feeder
  import systolic_pkg::*;
#(
  parameter int BITS = 8,
  parameter int DIM  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [idx_width(DIM)-1:0] wr_row,
  input  logic [DIM*BITS-1:0]       wr_data,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      arr_en,
  output logic [DIM*BITS-1:0]       A_out
);

  localparam int TW = cnt_width(DIM);
  localparam int AW = idx_width(DIM);

  logic signed [BITS-1:0] r_mem [DIM][DIM];

  feeder_state_t w_state;
  logic [TW-1:0] w_t;
  logic          w_wr_ok;

  feeder_ctrl #(
    .DIM (DIM),
    .TW  (TW)
  ) u_ctrl (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .o_state  (w_state),
    .o_t      (w_t),
    .o_busy   (busy),
    .o_done   (done),
    .o_arr_en (arr_en)
  );

  assign w_wr_ok = wr_en && ((w_state == IDLE) || (w_state == DONE)) && (int'(wr_row) < DIM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < DIM; r++) begin
        for (int k = 0; k < DIM; k++) begin
          r_mem[r][k] <= '0;
        end
      end
    end else if (w_wr_ok) begin
      for (int k = 0; k < DIM; k++) begin
        r_mem[wr_row][k] <= wr_data[k*BITS +: BITS];
      end
    end
  end

  // Offset is formed in full int width so lanes ahead of the wavefront read as zero, never alias.
  always_comb begin
    int w_off;
    w_off = 0;
    A_out = '0;
    if (w_state == FEED) begin
      for (int i = 0; i < DIM; i++) begin
        w_off = int'(w_t) - i;
        if ((w_off >= 0) && (w_off < DIM)) begin
          A_out[i*BITS +: BITS] = r_mem[i][w_off[AW-1:0]];
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_skew_feeder.sv
// Bench for operand_skew_feeder at DIM=4, BITS=8: scoreboard of per-cycle outputs plus scenario checks.
module tb_operand_skew_feeder;

  localparam int BITS = 8;
  localparam int DIM  = 4;
  localparam int W    = DIM * BITS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_en;
  logic [1:0]   wr_row;
  logic [W-1:0] wr_data;
  logic         start;
  logic         busy;
  logic         done;
  logic         arr_en;
  logic [W-1:0] A_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  operand_skew_feeder #(.BITS(BITS), .DIM(DIM)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_data (wr_data),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .arr_en  (arr_en),
    .A_out   (A_out)
  );

  typedef struct packed {
    logic         busy;
    logic         done;
    logic         arr_en;
    logic [W-1:0] a;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] mdl_mem [DIM][DIM];
  logic       mdl_acc = 1'b1;
  logic       mon_en  = 1'b0;

  function automatic logic [W-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
    logic [W-1:0] v;
    v[7:0]   = a0[7:0];
    v[15:8]  = a1[7:0];
    v[23:16] = a2[7:0];
    v[31:24] = a3[7:0];
    return v;
  endfunction

  function automatic logic [W-1:0] mdl_lanes(input int t);
    logic [W-1:0] v;
    int d;
    v = '0;
    for (int i = 0; i < DIM; i++) begin
      d = t - i;
      if (d >= 0 && d < DIM) v[i*8 +: 8] = mdl_mem[i][d];
    end
    return v;
  endfunction

  // Reference model: at each edge accept writes/starts only when the current cycle is IDLE or DONE.
  always @(posedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb_q.delete();
      for (int r = 0; r < DIM; r++)
        for (int k = 0; k < DIM; k++) mdl_mem[r][k] = 8'h00;
      mon_en = 1'b1;
    end else begin
      if (mdl_acc && wr_en)
        for (int k = 0; k < DIM; k++) mdl_mem[wr_row][k] = wr_data[k*8 +: 8];
      if (mdl_acc && start) begin
        for (int c = 0; c < 3*DIM-2; c++) begin
          e.busy   = 1'b1;
          e.done   = 1'b0;
          e.arr_en = 1'b1;
          e.a      = (c < 2*DIM-1) ? mdl_lanes(c) : '0;
          sb_q.push_back(e);
        end
        e      = '0;
        e.done = 1'b1;
        sb_q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (sb_q.size() > 0) e = sb_q.pop_front();
      else e = '0;
      mdl_acc = !e.busy;
      checks++;
      if ({busy, done, arr_en, A_out} !== e) begin
        failures++;
        $display("FAIL scoreboard t=%0t got busy=%b done=%b en=%b a=%h exp busy=%b done=%b en=%b a=%h",
                 $time, busy, done, arr_en, A_out, e.busy, e.done, e.arr_en, e.a);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_row(input logic [1:0] r, input logic [W-1:0] d);
    wr_en = 1'b1; wr_row = r; wr_data = d;
    next_cycle();
    wr_en = 1'b0;
  endtask

  task automatic load_ramp();
    for (int r = 0; r < DIM; r++)
      load_row(2'(r), pack4(4*r+1, 4*r+2, 4*r+3, 4*r+4));
  endtask

  task automatic test_reset();
    int en_cnt, nz_cnt, dj;
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      wr_en = 1'($urandom); start = 1'($urandom); wr_row = 2'($urandom); wr_data = $urandom;
      next_cycle();
    end
    rst_n = 1'b1; wr_en = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, arr_en, A_out} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b%b%b_%h exp=all zero", busy, done, arr_en, A_out);
    end
    next_cycle();
    start = 1'b1; next_cycle(); start = 1'b0;
    en_cnt = 0; nz_cnt = 0; dj = 0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (arr_en) en_cnt++;
      if (A_out !== '0) nz_cnt++;
      if (done) dj = j;
      next_cycle();
    end
    checks++;
    if (en_cnt != 10 || nz_cnt != 0 || dj != 11) begin
      failures++;
      $display("FAIL reset_zero_stream got en=%0d nz=%0d done_at=%0d exp en=10 nz=0 done_at=11", en_cnt, nz_cnt, dj);
    end
  endtask

  task automatic test_skew();
    int win_bad;
    load_ramp();
    start = 1'b1; next_cycle(); start = 1'b0;
    win_bad = 0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (arr_en !== (j <= 10) || busy !== (j <= 10) || done !== (j == 11)) win_bad++;
      if (j == 1) begin
        checks++;
        if (A_out !== pack4(1, 0, 0, 0)) begin failures++; $display("FAIL skew_t0 got=%h exp=%h", A_out, pack4(1, 0, 0, 0)); end
      end
      if (j == 2) begin
        checks++;
        if (A_out !== pack4(2, 5, 0, 0)) begin failures++; $display("FAIL skew_t1 got=%h exp=%h", A_out, pack4(2, 5, 0, 0)); end
      end
      if (j == 4) begin
        checks++;
        if (A_out !== pack4(4, 7, 10, 13)) begin failures++; $display("FAIL skew_t3 got=%h exp=%h", A_out, pack4(4, 7, 10, 13)); end
      end
      if (j == 7) begin
        checks++;
        if (A_out !== pack4(0, 0, 0, 16)) begin failures++; $display("FAIL skew_t6 got=%h exp=%h", A_out, pack4(0, 0, 0, 16)); end
      end
      next_cycle();
    end
    checks++;
    if (win_bad != 0) begin failures++; $display("FAIL skew_windows got=%0d bad cycles exp=0", win_bad); end
  endtask

  task automatic test_ignored();
    logic [W-1:0] gold [7];
    int bad;
    gold[0] = pack4(1, 0, 0, 0);   gold[1] = pack4(2, 5, 0, 0);
    gold[2] = pack4(3, 6, 9, 0);   gold[3] = pack4(4, 7, 10, 13);
    gold[4] = pack4(0, 8, 11, 14); gold[5] = pack4(0, 0, 12, 15);
    gold[6] = pack4(0, 0, 0, 16);
    start = 1'b1; next_cycle(); start = 1'b0;
    bad = 0;
    for (int j = 1; j <= 13; j++) begin
      if (j == 3) begin wr_en = 1'b1; wr_row = 2'd0; wr_data = pack4(9, 9, 9, 9); start = 1'b1; end
      else begin wr_en = 1'b0; start = 1'b0; end
      @(negedge clk);
      if (j <= 7 && A_out !== gold[j-1]) bad++;
      if (j > 7 && A_out !== '0) bad++;
      if (arr_en !== (j <= 10) || done !== (j == 11)) bad++;
      next_cycle();
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL ignored_stream got=%0d bad cycles exp=0", bad); end
    start = 1'b1; next_cycle(); start = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (j == 1) begin
        checks++;
        if (A_out[7:0] !== 8'd1) begin failures++; $display("FAIL ignored_row0_t0 got=%0d exp=1", A_out[7:0]); end
      end
      if (j == 4) begin
        checks++;
        if (A_out[7:0] !== 8'd4) begin failures++; $display("FAIL ignored_row0_t3 got=%0d exp=4", A_out[7:0]); end
      end
      next_cycle();
    end
  endtask

  task automatic test_sim_write_start();
    logic [7:0] exp3 [4];
    exp3[0] = 8'h80; exp3[1] = 8'hFF; exp3[2] = 8'h7F; exp3[3] = 8'h00;
    wr_en = 1'b1; wr_row = 2'd3; wr_data = pack4(-128, -1, 127, 0); start = 1'b1;
    next_cycle();
    wr_en = 1'b0; start = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (j >= 4 && j <= 7) begin
        checks++;
        if (A_out[31:24] !== exp3[j-4]) begin
          failures++;
          $display("FAIL simul_lane3_t%0d got=%h exp=%h", j-1, A_out[31:24], exp3[j-4]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    int en_cnt, nz_cnt;
    start = 1'b1; next_cycle(); start = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      if (j == 4) rst_n = 1'b0;
      @(negedge clk);
      next_cycle();
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, arr_en, A_out} !== '0) begin
      failures++;
      $display("FAIL midreset_idle got=%b%b%b_%h exp=all zero", busy, done, arr_en, A_out);
    end
    next_cycle();
    start = 1'b1; next_cycle(); start = 1'b0;
    en_cnt = 0; nz_cnt = 0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (arr_en) en_cnt++;
      if (A_out !== '0) nz_cnt++;
      next_cycle();
    end
    checks++;
    if (en_cnt != 10 || nz_cnt != 0) begin
      failures++;
      $display("FAIL midreset_cleared got en=%0d nz=%0d exp en=10 nz=0", en_cnt, nz_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int bad, gap;
    for (int r = 0; r < DIM; r++)
      load_row(2'(r), pack4(20+4*r+1, 20+4*r+2, 20+4*r+3, 20+4*r+4));
    start = 1'b1; next_cycle(); start = 1'b0;
    bad = 0; gap = 0;
    for (int j = 1; j <= 23; j++) begin
      if (j == 11) begin wr_en = 1'b1; wr_row = 2'd0; wr_data = pack4(77, 78, 79, 80); start = 1'b1; end
      else begin wr_en = 1'b0; start = 1'b0; end
      @(negedge clk);
      if (arr_en !== ((j >= 1 && j <= 10) || (j >= 12 && j <= 21))) bad++;
      if (done !== (j == 11 || j == 22)) bad++;
      if (j > 10 && j < 12 && !arr_en) gap++;
      if (j == 12) begin
        checks++;
        if (A_out[7:0] !== 8'd77) begin failures++; $display("FAIL b2b_lane0_t0 got=%0d exp=77", A_out[7:0]); end
      end
      if (j == 13) begin
        checks++;
        if (A_out[15:8] !== 8'd25) begin failures++; $display("FAIL b2b_lane1_t1 got=%0d exp=25", A_out[15:8]); end
      end
      next_cycle();
    end
    checks++;
    if (bad != 0 || gap != 1) begin
      failures++;
      $display("FAIL b2b_windows got bad=%0d gap=%0d exp bad=0 gap=1", bad, gap);
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; start = 1'b0; wr_row = '0; wr_data = '0;
    test_reset();
    test_skew();
    test_ignored();
    test_sim_write_start();
    test_reset_mid();
    test_back_to_back();
    repeat (3) next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
